// File: rtl/serial_frame_rx_if.sv
// rtl/serial_frame_rx_if.sv - serial line in, framed word stream out
// Groups the bit-strobe input side and the word/frame output side of the receiver.
interface serial_frame_rx_if #(
   parameter int unsigned DATA_W = 8
);
   localparam int unsigned BITS_W = $clog2(DATA_W + 1);

   logic              clk_en;
   logic              ser_in;
   logic              abort;
   logic [DATA_W-1:0] word;
   logic              word_valid;
   logic [BITS_W-1:0] word_bits;
   logic              word_last;
   logic              frame_done;
   logic              busy;
   logic              ser_out;
   logic              ser_out_valid;

   modport master (
      output clk_en, ser_in, abort,
      input  word, word_valid, word_bits, word_last, frame_done, busy, ser_out, ser_out_valid
   );

   modport slave (
      input  clk_en, ser_in, abort,
      output word, word_valid, word_bits, word_last, frame_done, busy, ser_out, ser_out_valid
   );
endinterface

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - start-pattern hunter, length header reader, payload deserialiser
// Frames are START_PAT, an LEN_W-bit MSB-first bit count, then that many payload bits.
module serial_frame_rx #(
   parameter int unsigned      PAT_W     = 3,
   parameter logic [PAT_W-1:0] START_PAT = 3'b101,
   parameter int unsigned      LEN_W     = 8,
   parameter int unsigned      DATA_W    = 8
) (
   input logic              clk,
   input logic              rst,
   serial_frame_rx_if.slave bus
);
   // Shift registers keep one bit fewer than their window; the newest bit is ser_in itself.
   localparam int unsigned HW  = (PAT_W  > 1) ? PAT_W  - 1 : 1;
   localparam int unsigned LSW = (LEN_W  > 1) ? LEN_W  - 1 : 1;
   localparam int unsigned WSW = (DATA_W > 1) ? DATA_W - 1 : 1;
   localparam int unsigned PCW = $clog2(PAT_W + 1);
   localparam int unsigned LCW = $clog2(LEN_W + 1);
   localparam int unsigned FW  = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      LEN     = 2'd1,
      PAYLOAD = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [HW-1:0]     hist_q, hist_d;
   logic [PCW-1:0]    pfill_q, pfill_d;
   logic [LCW-1:0]    lcnt_q, lcnt_d;
   logic [LSW-1:0]    len_sr_q, len_sr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [FW-1:0]     wfill_q, wfill_d;
   logic [WSW-1:0]    word_sr_q, word_sr_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [FW-1:0]     word_bits_q, word_bits_d;
   logic              word_last_q, word_last_d;
   logic              word_valid_q, word_valid_d;
   logic              frame_done_q, frame_done_d;

   logic [HW:0]       pat_cat;
   logic [PAT_W-1:0]  pat_win;
   logic [LSW:0]      len_cat;
   logic [LEN_W-1:0]  len_val;
   logic [WSW:0]      word_cat;
   logic [DATA_W-1:0] word_nxt;
   logic [FW-1:0]     wfill_inc;
   logic              rem_last;

   assign pat_cat   = {hist_q, bus.ser_in};
   assign pat_win   = pat_cat[PAT_W-1:0];
   assign len_cat   = {len_sr_q, bus.ser_in};
   assign len_val   = len_cat[LEN_W-1:0];
   assign word_cat  = {word_sr_q, bus.ser_in};
   assign word_nxt  = word_cat[DATA_W-1:0];
   assign wfill_inc = wfill_q + FW'(1);
   assign rem_last  = (rem_q == LEN_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= HUNT;
         hist_q       <= '0;
         pfill_q      <= '0;
         lcnt_q       <= '0;
         len_sr_q     <= '0;
         rem_q        <= '0;
         wfill_q      <= '0;
         word_sr_q    <= '0;
         word_q       <= '0;
         word_bits_q  <= '0;
         word_last_q  <= 1'b0;
         word_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hist_q       <= hist_d;
         pfill_q      <= pfill_d;
         lcnt_q       <= lcnt_d;
         len_sr_q     <= len_sr_d;
         rem_q        <= rem_d;
         wfill_q      <= wfill_d;
         word_sr_q    <= word_sr_d;
         word_q       <= word_d;
         word_bits_q  <= word_bits_d;
         word_last_q  <= word_last_d;
         word_valid_q <= word_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      hist_d       = hist_q;
      pfill_d      = pfill_q;
      lcnt_d       = lcnt_q;
      len_sr_d     = len_sr_q;
      rem_d        = rem_q;
      wfill_d      = wfill_q;
      word_sr_d    = word_sr_q;
      word_d       = word_q;
      word_bits_d  = word_bits_q;
      word_last_d  = word_last_q;
      word_valid_d = 1'b0;
      frame_done_d = 1'b0;

      // Abort wins over any bit sampled on the same edge, including a frame-completing one.
      if (bus.abort) begin
         state_d   = HUNT;
         hist_d    = '0;
         pfill_d   = '0;
         lcnt_d    = '0;
         len_sr_d  = '0;
         rem_d     = '0;
         wfill_d   = '0;
         word_sr_d = '0;
      end else if (bus.clk_en) begin
         case (state_q)
            HUNT: begin
               hist_d = pat_cat[HW-1:0];
               if (pfill_q != PCW'(PAT_W)) begin
                  pfill_d = pfill_q + PCW'(1);
               end
               if ((pat_win == START_PAT) && (pfill_q >= PCW'(PAT_W - 1))) begin
                  state_d  = LEN;
                  hist_d   = '0;
                  pfill_d  = '0;
                  lcnt_d   = '0;
                  len_sr_d = '0;
               end
            end

            LEN: begin
               len_sr_d = len_cat[LSW-1:0];
               lcnt_d   = lcnt_q + LCW'(1);
               if (lcnt_q == LCW'(LEN_W - 1)) begin
                  lcnt_d   = '0;
                  len_sr_d = '0;
                  if (len_val == '0) begin
                     state_d      = HUNT;
                     frame_done_d = 1'b1;
                  end else begin
                     state_d   = PAYLOAD;
                     rem_d     = len_val;
                     wfill_d   = '0;
                     word_sr_d = '0;
                  end
               end
            end

            PAYLOAD: begin
               rem_d     = rem_q - LEN_W'(1);
               wfill_d   = wfill_inc;
               word_sr_d = word_cat[WSW-1:0];
               if ((wfill_inc == FW'(DATA_W)) || rem_last) begin
                  word_d       = word_nxt;
                  word_bits_d  = wfill_inc;
                  word_last_d  = rem_last;
                  word_valid_d = 1'b1;
                  wfill_d      = '0;
                  word_sr_d    = '0;
                  if (rem_last) begin
                     state_d      = HUNT;
                     frame_done_d = 1'b1;
                  end
               end
            end

            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   assign bus.word          = word_q;
   assign bus.word_bits     = word_bits_q;
   assign bus.word_last     = word_last_q;
   assign bus.word_valid    = word_valid_q;
   assign bus.frame_done    = frame_done_q;
   assign bus.busy          = (state_q != HUNT);
   // Pass-through is combinational so downstream sees each payload bit before it is sampled.
   assign bus.ser_out_valid = (state_q == PAYLOAD);
   assign bus.ser_out       = (state_q == PAYLOAD) & bus.ser_in;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - self-checking bench for serial_frame_rx
module tb_serial_frame_rx;
   localparam int       PAT_W     = 3;
   localparam logic [2:0] START_PAT = 3'b101;
   localparam int       LEN_W     = 8;
   localparam int       DATA_W    = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_frame_rx_if #(.DATA_W(DATA_W)) bus ();

   serial_frame_rx #(
      .PAT_W    (PAT_W),
      .START_PAT(START_PAT),
      .LEN_W    (LEN_W),
      .DATA_W   (DATA_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference: mode 0 = hunting, 1 = reading length, 2 = payload
   int m_mode;
   bit m_win[$];
   bit m_chunk[$];
   int m_len_cnt;
   int m_len;
   int m_rem;
   int e_word, e_bits, e_last, e_wv, e_fd;

   int got_word[$];
   int got_bits[$];
   int got_last[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_win.delete();
      m_chunk.delete();
      m_len_cnt = 0;
      m_len = 0;
      m_rem = 0;
      e_word = 0; e_bits = 0; e_last = 0; e_wv = 0; e_fd = 0;
   endtask

   function automatic int bits_value(input bit q[$]);
      int v = 0;
      foreach (q[i]) v = v * 2 + int'(q[i]);
      return v;
   endfunction

   task automatic model_step(input bit ce, input bit si, input bit ab);
      e_wv = 0;
      e_fd = 0;
      if (ab) begin
         m_mode = 0;
         m_win.delete();
         m_chunk.delete();
         m_len_cnt = 0;
         m_len = 0;
         return;
      end
      if (!ce) return;
      case (m_mode)
         0: begin
            m_win.push_back(si);
            if (m_win.size() > PAT_W) void'(m_win.pop_front());
            if (m_win.size() == PAT_W && bits_value(m_win) == int'(START_PAT)) begin
               m_mode = 1;
               m_win.delete();
               m_len_cnt = 0;
               m_len = 0;
            end
         end
         1: begin
            m_len = m_len * 2 + int'(si);
            m_len_cnt++;
            if (m_len_cnt == LEN_W) begin
               if (m_len == 0) begin
                  m_mode = 0;
                  e_fd = 1;
               end else begin
                  m_mode = 2;
                  m_rem = m_len;
                  m_chunk.delete();
               end
            end
         end
         default: begin
            m_chunk.push_back(si);
            m_rem--;
            if (m_chunk.size() == DATA_W || m_rem == 0) begin
               e_word = bits_value(m_chunk);
               e_bits = m_chunk.size();
               e_last = (m_rem == 0);
               e_wv = 1;
               m_chunk.delete();
               if (m_rem == 0) begin
                  m_mode = 0;
                  e_fd = 1;
               end
            end
         end
      endcase
   endtask

   task automatic step(input bit ce, input bit si, input bit ab);
      @(negedge clk);
      bus.clk_en = ce;
      bus.ser_in = si;
      bus.abort  = ab;
      #1;
      check("ser_out_valid", bus.ser_out_valid, (m_mode == 2));
      check("ser_out", bus.ser_out, (m_mode == 2) && si);
      model_step(ce, si, ab);
      @(posedge clk);
      #1;
      check("word_valid", bus.word_valid, e_wv);
      check("frame_done", bus.frame_done, e_fd);
      check("busy", bus.busy, (m_mode != 0));
      check("word", bus.word, e_word);
      check("word_bits", bus.word_bits, e_bits);
      check("word_last", bus.word_last, e_last);
      if (bus.word_valid === 1'b1) begin
         got_word.push_back(int'(bus.word));
         got_bits.push_back(int'(bus.word_bits));
         got_last.push_back(int'(bus.word_last));
      end
   endtask

   task automatic send(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], 1'b0);
   endtask

   task automatic clear_got();
      got_word.delete();
      got_bits.delete();
      got_last.delete();
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      check("rst_async_busy", bus.busy, 0);
      check("rst_async_sov", bus.ser_out_valid, 0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.clk_en = 1'b1;
         bus.ser_in = i[0];
         bus.abort  = 1'b0;
         @(posedge clk);
         #1;
         check("rst_word_valid", bus.word_valid, 0);
         check("rst_frame_done", bus.frame_done, 0);
         check("rst_busy", bus.busy, 0);
         check("rst_ser_out_valid", bus.ser_out_valid, 0);
         check("rst_word", bus.word, 0);
      end
      @(negedge clk);
      rst = 1'b1;
      bus.clk_en = 1'b0;
      bus.abort  = 1'b0;
   endtask

   task automatic run_basic_frame(input string tag);
      clear_got();
      send(3'b101, 3);
      send(8'd16, 8);
      send(8'hA5, 8);
      send(8'h3C, 8);
      check({tag, "_fd"}, bus.frame_done, 1);
      check({tag, "_nwords"}, got_word.size(), 2);
      if (got_word.size() == 2) begin
         check({tag, "_w0"}, got_word[0], 32'hA5);
         check({tag, "_b0"}, got_bits[0], 8);
         check({tag, "_l0"}, got_last[0], 0);
         check({tag, "_w1"}, got_word[1], 32'h3C);
         check({tag, "_l1"}, got_last[1], 1);
      end
   endtask

   task automatic rand_bit(input bit si);
      while ($urandom_range(0, 4) == 0)
         step(1'b0, 1'($urandom), $urandom_range(0, 199) == 0);
      step(1'b1, si, $urandom_range(0, 299) == 0);
   endtask

   initial begin
      logic [6:0] ovl;
      int len;

      rst = 1'b0;
      bus.clk_en = 1'b0;
      bus.ser_in = 1'b0;
      bus.abort  = 1'b0;
      model_reset();

      do_reset(4);

      run_basic_frame("t2");

      // Overlap: the pattern must be found only on the seventh bit
      ovl = 7'b1100101;
      for (int i = 6; i >= 1; i--) step(1'b1, ovl[i], 1'b0);
      check("t3_busy_before", bus.busy, 0);
      step(1'b1, ovl[0], 1'b0);
      check("t3_busy_after", bus.busy, 1);
      send(8'd0, 8);

      // Partial final word
      clear_got();
      send(3'b101, 3);
      send(8'd11, 8);
      send(8'hA5, 8);
      send(3'b110, 3);
      check("t4_nwords", got_word.size(), 2);
      if (got_word.size() == 2) begin
         check("t4_w0", got_word[0], 32'hA5);
         check("t4_b0", got_bits[0], 8);
         check("t4_w1", got_word[1], 32'h06);
         check("t4_b1", got_bits[1], 3);
         check("t4_l1", got_last[1], 1);
      end

      // Zero-length frame
      clear_got();
      send(3'b101, 3);
      send(8'd0, 8);
      check("t5_fd", bus.frame_done, 1);
      check("t5_busy", bus.busy, 0);
      check("t5_nwords", got_word.size(), 0);

      // Strobe gaps then abort mid-payload
      clear_got();
      send(3'b101, 3);
      send(8'd16, 8);
      send(8'hA5, 8);
      send(3'b001, 3);
      for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom), 1'b0);
      check("t6_busy_hold", bus.busy, 1);
      send(2'b11, 2);
      step(1'b1, 1'b1, 1'b1);
      check("t6_abort_busy", bus.busy, 0);
      check("t6_abort_nwords", got_word.size(), 1);
      run_basic_frame("t6_rerun");

      // Abort together with the frame-completing bit
      send(3'b101, 3);
      send(8'd8, 8);
      send(7'h55, 7);
      step(1'b1, 1'b1, 1'b1);
      check("abort_last_fd", bus.frame_done, 0);
      check("abort_last_wv", bus.word_valid, 0);

      // Reset in the middle of a frame
      send(3'b101, 3);
      send(8'd20, 8);
      send(4'hF, 4);
      do_reset(2);

      // Random framed traffic with noise, strobe gaps and occasional aborts
      for (int f = 0; f < 40; f++) begin
         for (int n = $urandom_range(0, 6); n > 0; n--) rand_bit(1'($urandom));
         rand_bit(1'b1);
         rand_bit(1'b0);
         rand_bit(1'b1);
         len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
         for (int i = LEN_W - 1; i >= 0; i--) rand_bit(1'(len >> i));
         for (int i = 0; i < len; i++) rand_bit(1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
